// File: rtl/hdmi_text_axi_regs.sv
// AXI4-Lite register front end for the HDMI text controller: dual-port VRAM
// (AXI on port A, draw logic on port B) plus an 8-entry palette.
module hdmi_text_axi_regs #(
  parameter int C_AXI_DATA_WIDTH = 32,
  parameter int C_AXI_ADDR_WIDTH = 16,
  parameter int VRAM_WORDS       = 1200
) (
  input  logic                                axi_aclk,
  input  logic                                axi_areset,
  input  logic [C_AXI_ADDR_WIDTH-1:0]         axi_awaddr,
  input  logic [2:0]                          axi_awprot,
  input  logic                                axi_awvalid,
  output logic                                axi_awready,
  input  logic [C_AXI_DATA_WIDTH-1:0]         axi_wdata,
  input  logic [C_AXI_DATA_WIDTH/8-1:0]       axi_wstrb,
  input  logic                                axi_wvalid,
  output logic                                axi_wready,
  output logic [1:0]                          axi_bresp,
  output logic                                axi_bvalid,
  input  logic                                axi_bready,
  input  logic [C_AXI_ADDR_WIDTH-1:0]         axi_araddr,
  input  logic [2:0]                          axi_arprot,
  input  logic                                axi_arvalid,
  output logic                                axi_arready,
  output logic [C_AXI_DATA_WIDTH-1:0]         axi_rdata,
  output logic [1:0]                          axi_rresp,
  output logic                                axi_rvalid,
  input  logic                                axi_rready,
  input  logic [$clog2(VRAM_WORDS)-1:0]       vid_addr,
  output logic [C_AXI_DATA_WIDTH-1:0]         vid_data,
  output logic [8*C_AXI_DATA_WIDTH-1:0]       palette_out
);

  localparam int WI = C_AXI_ADDR_WIDTH - 2;
  localparam int NB = C_AXI_DATA_WIDTH / 8;
  localparam int VA = $clog2(VRAM_WORDS);
  localparam logic [WI-1:0] PAL_BASE = WI'(16'h0800);

  typedef enum logic [1:0] {W_COLLECT, W_COMMIT, W_RESP} wstate_t;
  typedef enum logic [1:0] {R_IDLE, R_ACCESS, R_DATA} rstate_t;

  function automatic logic is_vram(input logic [WI-1:0] idx);
    return idx < WI'(VRAM_WORDS);
  endfunction

  function automatic logic is_pal(input logic [WI-1:0] idx);
    return idx[WI-1:3] == PAL_BASE[WI-1:3];
  endfunction

  logic [C_AXI_DATA_WIDTH-1:0] vram [0:VRAM_WORDS-1];
  logic [C_AXI_DATA_WIDTH-1:0] palette_reg [0:7];

  wstate_t                     wstate_reg;
  logic                        awready_reg, wready_reg, bvalid_reg;
  logic                        aw_done_reg, w_done_reg;
  logic [WI-1:0]               waddr_reg;
  logic [C_AXI_DATA_WIDTH-1:0] wdata_reg;
  logic [NB-1:0]               wstrb_reg;

  rstate_t                     rstate_reg;
  logic                        arready_reg, rvalid_reg, issued_reg;
  logic [WI-1:0]               raddr_reg;
  logic [C_AXI_DATA_WIDTH-1:0] rdata_reg, ram_q_reg, pal_q_reg, vid_data_reg;

  logic commit, wr_vram, wr_pal, rd_vram, rd_pal, rd_issue, aw_hs, w_hs;
  logic unused_bits;

  assign commit   = (wstate_reg == W_COMMIT);
  assign wr_vram  = is_vram(waddr_reg);
  assign wr_pal   = is_pal(waddr_reg);
  assign rd_vram  = is_vram(raddr_reg);
  assign rd_pal   = is_pal(raddr_reg);
  // Port A is shared: a pending read waits out any write commit so it sees the new data.
  assign rd_issue = (rstate_reg == R_ACCESS) && !issued_reg && !commit;
  assign aw_hs    = axi_awvalid && awready_reg;
  assign w_hs     = axi_wvalid && wready_reg;

  assign unused_bits = ^{axi_awprot, axi_arprot, axi_awaddr[1:0], axi_araddr[1:0]};

  assign axi_awready = awready_reg;
  assign axi_wready  = wready_reg;
  assign axi_bvalid  = bvalid_reg;
  assign axi_bresp   = 2'b00;
  assign axi_arready = arready_reg;
  assign axi_rvalid  = rvalid_reg;
  assign axi_rdata   = rdata_reg;
  assign axi_rresp   = 2'b00;
  assign vid_data    = vid_data_reg;

  genvar gi;
  generate
    for (gi = 0; gi < 8; gi++) begin : g_pal_out
      assign palette_out[C_AXI_DATA_WIDTH*gi +: C_AXI_DATA_WIDTH] = palette_reg[gi];
    end
  endgenerate

  // VRAM port A: byte-masked write on commit, otherwise the AXI read access.
  always_ff @(posedge axi_aclk) begin
    if (!axi_areset && commit && wr_vram) begin
      for (int b = 0; b < NB; b++) begin
        if (wstrb_reg[b]) begin
          vram[waddr_reg[VA-1:0]][8*b +: 8] <= wdata_reg[8*b +: 8];
        end
      end
    end else if (rd_issue && rd_vram) begin
      ram_q_reg <= vram[raddr_reg[VA-1:0]];
    end
  end

  // VRAM port B: read-only for the renderer.
  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      vid_data_reg <= '0;
    end else begin
      vid_data_reg <= vram[vid_addr];
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      wstate_reg  <= W_COLLECT;
      awready_reg <= 1'b0;
      wready_reg  <= 1'b0;
      bvalid_reg  <= 1'b0;
      aw_done_reg <= 1'b0;
      w_done_reg  <= 1'b0;
      waddr_reg   <= '0;
      wdata_reg   <= '0;
      wstrb_reg   <= '0;
      for (int p = 0; p < 8; p++) begin
        palette_reg[p] <= '0;
      end
    end else begin
      case (wstate_reg)
        W_COLLECT: begin
          if (aw_hs) begin
            waddr_reg   <= axi_awaddr[C_AXI_ADDR_WIDTH-1:2];
            aw_done_reg <= 1'b1;
            awready_reg <= 1'b0;
          end else if (!aw_done_reg) begin
            awready_reg <= 1'b1;
          end
          if (w_hs) begin
            wdata_reg  <= axi_wdata;
            wstrb_reg  <= axi_wstrb;
            w_done_reg <= 1'b1;
            wready_reg <= 1'b0;
          end else if (!w_done_reg) begin
            wready_reg <= 1'b1;
          end
          if ((aw_done_reg || aw_hs) && (w_done_reg || w_hs)) begin
            wstate_reg <= W_COMMIT;
          end
        end
        W_COMMIT: begin
          if (wr_pal) begin
            for (int b = 0; b < NB; b++) begin
              if (wstrb_reg[b]) begin
                palette_reg[waddr_reg[2:0]][8*b +: 8] <= wdata_reg[8*b +: 8];
              end
            end
          end
          bvalid_reg <= 1'b1;
          wstate_reg <= W_RESP;
        end
        W_RESP: begin
          if (axi_bready) begin
            bvalid_reg  <= 1'b0;
            aw_done_reg <= 1'b0;
            w_done_reg  <= 1'b0;
            awready_reg <= 1'b1;
            wready_reg  <= 1'b1;
            wstate_reg  <= W_COLLECT;
          end
        end
        default: wstate_reg <= W_COLLECT;
      endcase
    end
  end

  always_ff @(posedge axi_aclk) begin
    if (axi_areset) begin
      rstate_reg  <= R_IDLE;
      arready_reg <= 1'b0;
      rvalid_reg  <= 1'b0;
      issued_reg  <= 1'b0;
      raddr_reg   <= '0;
      rdata_reg   <= '0;
      pal_q_reg   <= '0;
    end else begin
      case (rstate_reg)
        R_IDLE: begin
          if (axi_arvalid && arready_reg) begin
            raddr_reg   <= axi_araddr[C_AXI_ADDR_WIDTH-1:2];
            arready_reg <= 1'b0;
            issued_reg  <= 1'b0;
            rstate_reg  <= R_ACCESS;
          end else begin
            arready_reg <= 1'b1;
          end
        end
        R_ACCESS: begin
          if (!issued_reg) begin
            if (rd_issue) begin
              issued_reg <= 1'b1;
              pal_q_reg  <= rd_pal ? palette_reg[raddr_reg[2:0]] : '0;
            end
          end else begin
            rdata_reg  <= rd_vram ? ram_q_reg : pal_q_reg;
            rvalid_reg <= 1'b1;
            rstate_reg <= R_DATA;
          end
        end
        R_DATA: begin
          if (axi_rready) begin
            rvalid_reg  <= 1'b0;
            arready_reg <= 1'b1;
            rstate_reg  <= R_IDLE;
          end
        end
        default: rstate_reg <= R_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hdmi_text_axi_regs.sv
// Directed bench for hdmi_text_axi_regs: table of write/readback vectors plus
// hand-written handshake, backpressure, stall and reset sequences.
module tb_hdmi_text_axi_regs;

  logic        clk = 1'b0;
  logic        axi_areset;
  logic [15:0] axi_awaddr, axi_araddr;
  logic [2:0]  axi_awprot, axi_arprot;
  logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
  logic [31:0] axi_wdata, axi_rdata, vid_data;
  logic [3:0]  axi_wstrb;
  logic [1:0]  axi_bresp, axi_rresp;
  logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;
  logic [10:0] vid_addr;
  logic [255:0] palette_out;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  hdmi_text_axi_regs dut (
    .axi_aclk(clk), .axi_areset(axi_areset),
    .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid), .axi_awready(axi_awready),
    .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb), .axi_wvalid(axi_wvalid), .axi_wready(axi_wready),
    .axi_bresp(axi_bresp), .axi_bvalid(axi_bvalid), .axi_bready(axi_bready),
    .axi_araddr(axi_araddr), .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
    .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid), .axi_rready(axi_rready),
    .vid_addr(vid_addr), .vid_data(vid_data), .palette_out(palette_out)
  );

  typedef struct {
    logic [15:0] waddr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [15:0] raddr;
    logic [31:0] rexp;
  } vec_t;

  vec_t vecs [10];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits for the B response (bready held high) and returns edges after the handshake edge.
  task automatic wait_bresp(output int edges);
    edges = 0;
    while (!axi_bvalid && edges < 50) begin
      tick();
      edges++;
    end
    check("bvalid_seen", {31'd0, axi_bvalid}, 32'd1);
    check("bresp", {30'd0, axi_bresp}, 32'd0);
    tick();
    axi_bready = 1'b0;
  endtask

  task automatic do_write(input logic [15:0] a, input logic [31:0] d, input logic [3:0] s, output int edges);
    int  guard;
    logic ta, tw;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = s;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b1;
    guard = 0;
    while ((axi_awvalid || axi_wvalid) && guard < 50) begin
      ta = axi_awvalid && axi_awready;
      tw = axi_wvalid && axi_wready;
      tick();
      if (ta) axi_awvalid = 1'b0;
      if (tw) axi_wvalid = 1'b0;
      guard++;
    end
    if (guard >= 50) begin
      check("aw_w_accept_timeout", 32'd1, 32'd0);
      axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    end
    wait_bresp(edges);
  endtask

  task automatic do_read(input logic [15:0] a, output logic [31:0] d, output int edges);
    int guard;
    axi_araddr = a; axi_arvalid = 1'b1; axi_rready = 1'b1;
    guard = 0;
    while (!axi_arready && guard < 50) begin
      tick();
      guard++;
    end
    tick();
    axi_arvalid = 1'b0;
    edges = 0;
    while (!axi_rvalid && edges < 50) begin
      tick();
      edges++;
    end
    check("rvalid_seen", {31'd0, axi_rvalid}, 32'd1);
    check("rresp", {30'd0, axi_rresp}, 32'd0);
    d = axi_rdata;
    tick();
    axi_rready = 1'b0;
  endtask

  // One channel first, the other after a three-cycle gap.
  task automatic do_split(input logic [15:0] a, input logic [31:0] d, input logic aw_first);
    int  edges;
    logic ok;
    axi_awaddr = a; axi_wdata = d; axi_wstrb = 4'hF; axi_bready = 1'b1;
    if (aw_first) axi_awvalid = 1'b1; else axi_wvalid = 1'b1;
    check(aw_first ? "split_awready_idle" : "split_wready_idle",
          {31'd0, aw_first ? axi_awready : axi_wready}, 32'd1);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (aw_first) ok &= !axi_awready && axi_wready;
      else          ok &= !axi_wready && axi_awready;
      tick();
    end
    check(aw_first ? "split_aw_first_readies" : "split_w_first_readies", {31'd0, ok}, 32'd1);
    if (aw_first) axi_wvalid = 1'b1; else axi_awvalid = 1'b1;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    wait_bresp(edges);
    check("split_b_latency", edges, 32'd1);
  endtask

  initial begin
    logic [31:0] rd, d0;
    int          be, re, bedge, redge;
    logic        ok;

    vecs[0] = '{16'h0014, 32'hDEADBEEF, 4'hF, 16'h0014, 32'hDEADBEEF};
    vecs[1] = '{16'h0028, 32'h11223344, 4'hF, 16'h0028, 32'h11223344};
    vecs[2] = '{16'h0028, 32'hAABBCCDD, 4'h2, 16'h0028, 32'h1122CC44};
    vecs[3] = '{16'h200C, 32'h01E0F01E, 4'hF, 16'h200C, 32'h01E0F01E};
    vecs[4] = '{16'h1770, 32'hFFFFFFFF, 4'hF, 16'h1770, 32'h00000000};
    vecs[5] = '{16'h0014, 32'h00000000, 4'h0, 16'h0014, 32'hDEADBEEF};
    vecs[6] = '{16'h201C, 32'hA5A5FFFF, 4'h3, 16'h201C, 32'h0000FFFF};
    vecs[7] = '{16'h12BC, 32'h5A5A5A5A, 4'hF, 16'h12BC, 32'h5A5A5A5A};
    vecs[8] = '{16'h12C0, 32'h77777777, 4'hF, 16'h12C0, 32'h00000000};
    vecs[9] = '{16'h2000, 32'h12345678, 4'h8, 16'h2000, 32'h12000000};

    axi_areset = 1'b1;
    axi_awaddr = '0; axi_araddr = '0; axi_awprot = '0; axi_arprot = '0;
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_wdata = '0; axi_wstrb = '0;
    axi_bready = 1'b0; axi_arvalid = 1'b0; axi_rready = 1'b0; vid_addr = '0;
    repeat (3) tick();
    check("rst_readies", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd0);
    check("rst_valids", {30'd0, axi_bvalid, axi_rvalid}, 32'd0);
    check("rst_resp", {28'd0, axi_bresp, axi_rresp}, 32'd0);
    check("rst_rdata", axi_rdata, 32'd0);
    check("rst_vid_data", vid_data, 32'd0);
    check("rst_palette", {31'd0, |palette_out}, 32'd0);
    axi_areset = 1'b0;
    check("readies_before_first_edge", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd0);
    tick();
    check("readies_after_release", {29'd0, axi_awready, axi_wready, axi_arready}, 32'h7);

    for (int i = 0; i < 10; i++) begin
      do_write(vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, be);
      check($sformatf("v%0d_b_latency", i), be, 32'd1);
      do_read(vecs[i].raddr, rd, re);
      check($sformatf("v%0d_r_latency", i), re, 32'd2);
      check($sformatf("v%0d_rdata", i), rd, vecs[i].rexp);
      $display("vec %0d: wr %h=%h strb %h rd %h=%h", i, vecs[i].waddr, vecs[i].wdata, vecs[i].wstrb, vecs[i].raddr, rd);
    end

    check("palette3_out", palette_out[127:96], 32'h01E0F01E);
    check("palette7_out", palette_out[255:224], 32'h0000FFFF);
    check("palette0_out", palette_out[31:0], 32'h12000000);
    do_read(16'h0014, rd, re);
    check("word5_untouched", rd, 32'hDEADBEEF);
    do_read(16'h12BC, rd, re);
    check("word1199_untouched", rd, 32'h5A5A5A5A);

    vid_addr = 11'd5;
    tick();
    check("vid_word5", vid_data, 32'hDEADBEEF);
    vid_addr = 11'd10;
    tick();
    check("vid_word10", vid_data, 32'h1122CC44);

    do_split(16'h001C, 32'h12345678, 1'b1);
    do_read(16'h001C, rd, re);
    check("split_aw_first_rdata", rd, 32'h12345678);
    do_split(16'h0024, 32'h12345678, 1'b0);
    do_read(16'h0024, rd, re);
    check("split_w_first_rdata", rd, 32'h12345678);
    $display("split writes done");

    // Write response backpressure with a second write queued behind it.
    axi_awaddr = 16'h0078; axi_wdata = 32'h0BADF00D; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    be = 0;
    while (!axi_bvalid && be < 50) begin
      tick();
      be++;
    end
    axi_awaddr = 16'h007C; axi_wdata = 32'h31313131;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      ok &= axi_bvalid && !axi_awready && !axi_wready;
      tick();
    end
    check("bready_hold", {31'd0, ok}, 32'd1);
    axi_bready = 1'b1;
    tick();
    check("readies_after_b_hs", {30'd0, axi_awready, axi_wready}, 32'h3);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    wait_bresp(be);
    check("second_write_b_latency", be, 32'd1);
    do_read(16'h0078, rd, re);
    check("held_write_rdata", rd, 32'h0BADF00D);
    do_read(16'h007C, rd, re);
    check("queued_write_rdata", rd, 32'h31313131);
    $display("bready backpressure done");

    // Read data backpressure.
    axi_araddr = 16'h0078; axi_arvalid = 1'b1; axi_rready = 1'b0;
    tick();
    axi_arvalid = 1'b0;
    re = 0;
    while (!axi_rvalid && re < 50) begin
      tick();
      re++;
    end
    d0 = axi_rdata;
    check("rready_hold_data", d0, 32'h0BADF00D);
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      ok &= axi_rvalid && (axi_rdata == 32'h0BADF00D) && !axi_arready;
    end
    check("rready_hold", {31'd0, ok}, 32'd1);
    axi_rready = 1'b1;
    tick();
    axi_rready = 1'b0;
    check("after_r_hs", {30'd0, axi_rvalid, axi_arready}, 32'h1);
    $display("rready backpressure done");

    // AR lands on the same edge as the AW/W handshake: the read access collides with the commit.
    axi_awaddr = 16'h0050; axi_wdata = 32'hCAFEF00D; axi_wstrb = 4'hF;
    axi_araddr = 16'h0050;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_arvalid = 1'b1;
    axi_bready = 1'b1; axi_rready = 1'b1;
    check("stall_readies", {29'd0, axi_awready, axi_wready, axi_arready}, 32'h7);
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0; axi_arvalid = 1'b0;
    bedge = 0; redge = 0; rd = '0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (axi_bvalid && bedge == 0) bedge = i;
      if (axi_rvalid && redge == 0) begin
        redge = i;
        rd = axi_rdata;
      end
    end
    axi_bready = 1'b0; axi_rready = 1'b0;
    check("stall_b_latency", bedge, 32'd1);
    check("stall_r_latency", redge, 32'd3);
    check("stall_rdata", rd, 32'hCAFEF00D);
    $display("commit/read collision: b %0d r %0d data %h", bedge, redge, rd);

    // Reset while the write response is pending.
    axi_awaddr = 16'h0060; axi_wdata = 32'h0000BEEF; axi_wstrb = 4'hF;
    axi_awvalid = 1'b1; axi_wvalid = 1'b1; axi_bready = 1'b0;
    tick();
    axi_awvalid = 1'b0; axi_wvalid = 1'b0;
    be = 0;
    while (!axi_bvalid && be < 50) begin
      tick();
      be++;
    end
    check("pre_reset_bvalid", {31'd0, axi_bvalid}, 32'd1);
    axi_areset = 1'b1;
    tick();
    check("reset_drops_bvalid", {31'd0, axi_bvalid}, 32'd0);
    check("reset_readies_low", {29'd0, axi_awready, axi_wready, axi_arready}, 32'd0);
    axi_areset = 1'b0;
    tick();
    check("readies_after_midreset", {29'd0, axi_awready, axi_wready, axi_arready}, 32'h7);
    check("bvalid_after_midreset", {31'd0, axi_bvalid}, 32'd0);
    $display("reset during response done");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
